// File: rtl/mux_tdm_nl.sv
// mux_tdm_nl: N-lane time-division multiplexer on the fast clock.
// A rotating selector serialises N_LANES parallel lane words onto one registered
// stream, with lane-enable masking, align-to-lane-0, lane/frame tags and a
// saturating idle-slot counter.
// Optional build macro MUX_TDM_IDLE_FILL_EN: invalid slots drive IDLE_WORD on
// data_out instead of holding the previous word.
module mux_tdm_nl #(
    parameter int unsigned          N_LANES   = 4,
    parameter int unsigned          DATA_W    = 8,
    parameter int unsigned          CNT_W     = 16,
    parameter logic [DATA_W-1:0]    IDLE_WORD = 8'hBC
) (
    input  logic                        clk_nf,
    input  logic                        reset,
    input  logic [N_LANES*DATA_W-1:0]   data_in,
    input  logic [N_LANES-1:0]          valid_in,
    input  logic [N_LANES-1:0]          lane_en,
    input  logic                        align,
    input  logic                        cnt_clr,
    output logic [DATA_W-1:0]           data_out,
    output logic                        valid_out,
    output logic [((N_LANES > 1) ? $clog2(N_LANES) : 1)-1:0] lane_out,
    output logic                        frame_out,
    output logic [CNT_W-1:0]            idle_cnt
);

    localparam int unsigned SEL_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  slot;
    logic [DATA_W-1:0] lane_word;
    logic              lane_vld;
    logic              lane_on;
    logic              slot_valid;

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q;
    logic [SEL_W-1:0]  lane_q;
    logic              frame_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Effective slot: align overrides the rotating selector with lane 0.
    always_comb begin
        slot = align ? '0 : sel_q;
    end

    // Pick the current slot's word, valid and enable; other lanes are ignored.
    always_comb begin
        lane_word = '0;
        lane_vld  = 1'b0;
        lane_on   = 1'b0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (slot == SEL_W'(i)) begin
                lane_word = data_in[i*DATA_W +: DATA_W];
                lane_vld  = valid_in[i];
                lane_on   = lane_en[i];
            end
        end
    end

    // Next-state for selector, data word and idle counter.
    always_comb begin
        slot_valid = lane_vld & lane_on;

        // Explicit wrap so non-power-of-2 lane counts never reach N_LANES.
        sel_d = (slot == SEL_W'(N_LANES - 1)) ? '0 : slot + SEL_W'(1);

        if (slot_valid) begin
            data_d = lane_word;
        end else begin
`ifdef MUX_TDM_IDLE_FILL_EN
            data_d = IDLE_WORD;
`else
            data_d = data_q;
`endif
        end

        // Clear wins over the increment; disabled lanes are never idle.
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (lane_on && !lane_vld && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and output registers; reset restarts the frame at lane 0.
    always_ff @(posedge clk_nf) begin
        if (reset) begin
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            lane_q  <= '0;
            frame_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= slot_valid;
            lane_q  <= slot;
            frame_q <= (slot == '0);
            cnt_q   <= cnt_d;
        end
    end

    // Drive ports straight from the registers.
    always_comb begin
        data_out  = data_q;
        valid_out = valid_q;
        lane_out  = lane_q;
        frame_out = frame_q;
        idle_cnt  = cnt_q;
    end

endmodule
